// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the next-PC sequencer: FSM states,
// redirect-source encoding and the sequential PC step.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    REDIR_NONE   = 3'd0,
    REDIR_TRAP   = 3'd1,
    REDIR_MRET   = 3'd2,
    REDIR_JUMP   = 3'd3,
    REDIR_BRANCH = 3'd4
  } redir_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_redirect_arbiter.sv
// Combinational fixed-priority select among trap, mret, jump and branch;
// returns the winning source and its raw (unaligned) target.
module pc_redirect_arbiter
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        trap_req,
  input  logic        mret_req,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] mepc,
  output redir_t      src,
  output logic [31:0] target
);

  always_comb begin
    src    = REDIR_NONE;
    target = 32'h0;
    if (trap_req) begin
      src    = REDIR_TRAP;
      target = TRAP_VECTOR;
    end else if (mret_req) begin
      src    = REDIR_MRET;
      target = mepc;
    end else if (jump_valid) begin
      src    = REDIR_JUMP;
      target = jump_target;
    end else if (branch_taken) begin
      src    = REDIR_BRANCH;
      target = branch_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: BOOT/RUN/HALT FSM, redirect arbitration, mepc, flush
// and redirect counter. Optional PC_SEQ_MISALIGN_CHECK_EN turns misaligned
// targets into traps and adds the misalign_trap output.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] current_pc,
  output logic [31:0] next_pc,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        trap_req,
  input  logic        mret_req,
  input  logic        halt_req,
  input  logic        resume,
  output logic        flush,
  output logic [31:0] mepc,
`ifdef PC_SEQ_MISALIGN_CHECK_EN
  output logic        misalign_trap,
`endif
  output logic [15:0] redirect_cnt
);

  state_t      state_reg, state_next;
  logic [31:0] mepc_reg, mepc_next;
  logic        mepc_load;
  logic        flush_reg;
  logic [15:0] cnt_reg;
  logic        take;
  redir_t      arb_src;
  logic [31:0] arb_target;
`ifdef PC_SEQ_MISALIGN_CHECK_EN
  logic        misalign_reg, misalign_hit;
`endif

  pc_redirect_arbiter #(.TRAP_VECTOR(TRAP_VECTOR)) u_arb (
    .trap_req      (trap_req),
    .mret_req      (mret_req),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mepc          (mepc_reg),
    .src           (arb_src),
    .target        (arb_target)
  );

  always_comb begin
    state_next = state_reg;
    next_pc    = current_pc;
    fetch_req  = 1'b0;
    take       = 1'b0;
    mepc_load  = 1'b0;
    mepc_next  = current_pc;
`ifdef PC_SEQ_MISALIGN_CHECK_EN
    misalign_hit = 1'b0;
`endif
    case (state_reg)
      BOOT: begin
        next_pc    = RESET_VECTOR;
        state_next = RUN;
      end
      RUN: begin
        fetch_req = 1'b1;
        if (arb_src == REDIR_TRAP) begin
          take      = 1'b1;
          next_pc   = TRAP_VECTOR;
          mepc_load = 1'b1;
        end else if (arb_src != REDIR_NONE) begin
          take = 1'b1;
`ifdef PC_SEQ_MISALIGN_CHECK_EN
          // A misaligned target becomes a trap that records the bad target.
          if (arb_target[1:0] != 2'b00) begin
            next_pc      = TRAP_VECTOR;
            mepc_load    = 1'b1;
            mepc_next    = arb_target;
            misalign_hit = 1'b1;
          end else begin
            next_pc = arb_target;
          end
`else
          next_pc = arb_target & ~32'h3;
`endif
        end else if (halt_req) begin
          state_next = HALT;
        end else if (!stall && fetch_ack) begin
          next_pc = current_pc + PC_STEP;
        end
      end
      HALT: begin
        if (arb_src == REDIR_TRAP) begin
          take       = 1'b1;
          next_pc    = TRAP_VECTOR;
          mepc_load  = 1'b1;
          state_next = RUN;
        end else if (resume) begin
          state_next = RUN;
        end
      end
      default: begin
        next_pc    = RESET_VECTOR;
        state_next = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= BOOT;
      mepc_reg  <= 32'h0;
      flush_reg <= 1'b0;
      cnt_reg   <= 16'h0;
    end else begin
      state_reg <= state_next;
      flush_reg <= take;
      if (mepc_load) mepc_reg <= mepc_next;
      if (take) cnt_reg <= cnt_reg + 16'd1;
    end
  end

`ifdef PC_SEQ_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_reg <= 1'b0;
    else     misalign_reg <= misalign_hit;
  end
  assign misalign_trap = misalign_reg;
`endif

  assign flush        = flush_reg;
  assign mepc         = mepc_reg;
  assign redirect_cnt = cnt_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes hand-computed per-cycle
// expectations; a negedge monitor pops and compares DUT outputs.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] current_pc;
  logic [31:0] next_pc;
  logic        fetch_req, fetch_ack, stall;
  logic        branch_taken, jump_valid, trap_req, mret_req, halt_req, resume;
  logic [31:0] branch_target, jump_target;
  logic        flush;
  logic [31:0] mepc;
  logic [15:0] redirect_cnt;
`ifdef PC_SEQ_MISALIGN_CHECK_EN
  logic        misalign_trap;
  localparam logic [31:0] MEPC_M = 32'h0000_0082;
`else
  localparam logic [31:0] MEPC_M = 32'h0000_0018;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] npc;
    logic        freq;
    logic        fl;
    logic [31:0] mepc;
    logic [15:0] cnt;
    logic        mis;
    logic [95:0] name;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .current_pc    (current_pc),
    .next_pc       (next_pc),
    .fetch_req     (fetch_req),
    .fetch_ack     (fetch_ack),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .trap_req      (trap_req),
    .mret_req      (mret_req),
    .halt_req      (halt_req),
    .resume        (resume),
    .flush         (flush),
    .mepc          (mepc),
`ifdef PC_SEQ_MISALIGN_CHECK_EN
    .misalign_trap (misalign_trap),
`endif
    .redirect_cnt  (redirect_cnt)
  );

  // Stand-in for program_counter
  always @(posedge clk or posedge rst) begin
    if (rst) current_pc <= 32'h0;
    else     current_pc <= next_pc;
  end

  task automatic chk(input logic [95:0] name, input string field,
                     input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %0s %s got %h exp %h", name, field, got, want);
    end
  endtask

  // Monitor: one expectation per observed cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "next_pc", next_pc, e.npc);
      chk(e.name, "fetch_req", {31'h0, fetch_req}, {31'h0, e.freq});
      chk(e.name, "flush", {31'h0, flush}, {31'h0, e.fl});
      chk(e.name, "mepc", mepc, e.mepc);
      chk(e.name, "redirect_cnt", {16'h0, redirect_cnt}, {16'h0, e.cnt});
`ifdef PC_SEQ_MISALIGN_CHECK_EN
      chk(e.name, "misalign_trap", {31'h0, misalign_trap}, {31'h0, e.mis});
`endif
      $display("cyc %0s pc=%h next=%h freq=%b flush=%b mepc=%h cnt=%0d",
               e.name, current_pc, next_pc, fetch_req, flush, mepc, redirect_cnt);
    end
  end

  task automatic step(input logic [31:0] npc, input logic freq, input logic fl,
                      input logic [31:0] m, input logic [15:0] cnt,
                      input logic mis, input logic [95:0] name);
    exp_t e;
    e.npc = npc; e.freq = freq; e.fl = fl; e.mepc = m;
    e.cnt = cnt; e.mis = mis; e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    stall = 0; branch_taken = 0; jump_valid = 0; trap_req = 0;
    mret_req = 0; halt_req = 0; resume = 0;
  endtask

  initial begin
    clear_reqs();
    fetch_ack = 0; branch_target = 0; jump_target = 0;
    repeat (2) @(posedge clk);
    #1;
    step(32'h0, 0, 0, 32'h0, 16'd0, 0, "reset");
    rst = 0; fetch_ack = 1;
    step(32'h0, 0, 0, 32'h0, 16'd0, 0, "boot");
    for (int i = 0; i < 8; i++)
      step(32'(4 * (i + 1)), 1, 0, 32'h0, 16'd0, 0, "seq");
    // current_pc = 0x20: stall holds
    stall = 1;
    for (int i = 0; i < 3; i++) step(32'h20, 1, 0, 32'h0, 16'd0, 0, "stall");
    stall = 0;
    step(32'h24, 1, 0, 32'h0, 16'd0, 0, "unstall");
    fetch_ack = 0;
    step(32'h24, 1, 0, 32'h0, 16'd0, 0, "no_ack");
    fetch_ack = 1;
    // jump beats branch and stall
    stall = 1; branch_taken = 1; branch_target = 32'h200;
    jump_valid = 1; jump_target = 32'h80;
    step(32'h80, 1, 0, 32'h0, 16'd0, 0, "jmp_prio");
    clear_reqs();
    step(32'h84, 1, 1, 32'h0, 16'd1, 0, "jmp_flush");
    step(32'h88, 1, 0, 32'h0, 16'd1, 0, "jmp_after");
    jump_valid = 1; jump_target = 32'h44;
    step(32'h44, 1, 0, 32'h0, 16'd1, 0, "jmp44");
    clear_reqs();
    // trap with simultaneous mret: trap wins
    trap_req = 1; mret_req = 1;
    step(32'h100, 1, 1, 32'h0, 16'd2, 0, "trap");
    trap_req = 0;
    step(32'h44, 1, 1, 32'h44, 16'd3, 0, "mret");
    mret_req = 0;
    step(32'h48, 1, 1, 32'h44, 16'd4, 0, "mret_flush");
    step(32'h4C, 1, 0, 32'h44, 16'd4, 0, "after_mret");
    jump_valid = 1; jump_target = 32'h10;
    step(32'h10, 1, 0, 32'h44, 16'd4, 0, "jmp10");
    clear_reqs();
    halt_req = 1;
    step(32'h10, 1, 1, 32'h44, 16'd5, 0, "halt_req");
    halt_req = 0; branch_taken = 1; branch_target = 32'h300;
    step(32'h10, 0, 0, 32'h44, 16'd5, 0, "halt_br1");
    step(32'h10, 0, 0, 32'h44, 16'd5, 0, "halt_br2");
    branch_taken = 0; resume = 1; fetch_ack = 0;
    step(32'h10, 0, 0, 32'h44, 16'd5, 0, "resume");
    resume = 0;
    step(32'h10, 1, 0, 32'h44, 16'd5, 0, "run_noack");
    fetch_ack = 1;
    step(32'h14, 1, 0, 32'h44, 16'd5, 0, "run_ack");
    step(32'h18, 1, 0, 32'h44, 16'd5, 0, "run_ack2");
    halt_req = 1;
    step(32'h18, 1, 0, 32'h44, 16'd5, 0, "halt2");
    halt_req = 0; trap_req = 1;
    step(32'h100, 0, 0, 32'h44, 16'd5, 0, "halt_trap");
    trap_req = 0;
    step(32'h104, 1, 1, 32'h18, 16'd6, 0, "trap_run");
    jump_valid = 1; jump_target = 32'h82;
`ifdef PC_SEQ_MISALIGN_CHECK_EN
    step(32'h100, 1, 0, 32'h18, 16'd6, 0, "misalign");
    clear_reqs();
    step(32'h104, 1, 1, MEPC_M, 16'd7, 1, "mis_after");
`else
    step(32'h80, 1, 0, 32'h18, 16'd6, 0, "misalign");
    clear_reqs();
    step(32'h84, 1, 1, MEPC_M, 16'd7, 0, "mis_after");
`endif
    jump_valid = 1; jump_target = 32'hFFFF_FFFC;
    step(32'hFFFF_FFFC, 1, 0, MEPC_M, 16'd7, 0, "jmp_top");
    clear_reqs();
    step(32'h0, 1, 1, MEPC_M, 16'd8, 0, "wrap");
    step(32'h4, 1, 0, MEPC_M, 16'd8, 0, "post_wrap");
    // asynchronous reset with a pending redirect
    rst = 1; jump_valid = 1; jump_target = 32'h500;
    step(32'h0, 0, 0, 32'h0, 16'd0, 0, "async_rst");
    rst = 0; clear_reqs();
    step(32'h0, 0, 0, 32'h0, 16'd0, 0, "boot2");
    step(32'h4, 1, 0, 32'h0, 16'd0, 0, "seq2");
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain queue got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the single-issue RISC-V core. It sits in front of `program_counter` and drives its `next_PC` input every cycle, arbitrating between the redirect sources (trap, mret, jump, branch), sequential advance, stall/hold and halt. It also sequences the instruction-fetch handshake, keeps the trap return address (mepc), and emits a pipeline flush pulse after every redirect.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'h0000_0000: first fetch address after reset.
- `TRAP_VECTOR`, default 32'h0000_0100: redirect target for all traps.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `current_pc`  in  32  registered PC from `program_counter`.
- `next_pc`  out  32  combinational; drives `program_counter.next_PC`.
- `fetch_req`  out  1  instruction fetch request at `current_pc`.
- `fetch_ack`  in  1  imem returned the instruction this cycle.
- `stall`  in  1  hazard hold from the decode/execute stage.
- `branch_taken`  in  1  conditional branch resolved taken.
- `branch_target`  in  32  branch destination.
- `jump_valid`  in  1  JAL/JALR resolved.
- `jump_target`  in  32  jump destination.
- `trap_req`  in  1  exception or ecall.
- `mret_req`  in  1  return from trap.
- `halt_req`  in  1  ebreak/debug halt.
- `resume`  in  1  leave HALT.
- `flush`  out  1  one-cycle pipeline kill.
- `mepc`  out  32  saved trap return address.
- `redirect_cnt`  out  16  count of accepted redirects, wraps at 16'hFFFF -> 0.

## Operation
- FSM states: BOOT, RUN, HALT.
- BOOT: entered on reset and held for one cycle after reset deasserts. `next_pc = RESET_VECTOR`, `fetch_req = 0`. Next state is RUN.
- RUN: `fetch_req = 1`. `next_pc` is chosen by fixed priority, highest first:
  - trap: `TRAP_VECTOR`; `mepc <= current_pc`.
  - mret: `mepc`.
  - jump: `jump_target`.
  - branch: `branch_target`.
  - halt: `current_pc`; next state is HALT.
  - stall or no `fetch_ack`: `current_pc` (hold).
  - otherwise: `current_pc + 4`, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Redirects (trap, mret, jump, branch) override `stall` and do not require `fetch_ack`. Only the highest-priority redirect is taken; lower simultaneous requests are dropped.
- Each accepted redirect sets `flush` in the following cycle and increments `redirect_cnt`.
- HALT: `fetch_req = 0`, `next_pc = current_pc`.
  - `resume` returns to RUN the next cycle.
  - `trap_req` in HALT is serviced as in RUN and returns to RUN.
  - All other requests are ignored.
- A simultaneous `trap_req` and `mret_req` is a trap: `mepc` is overwritten, no return is taken.

## Timing
- Values held while `rst` is high: state BOOT, `fetch_req` 0, `flush` 0, `mepc` 0, `redirect_cnt` 0, `next_pc = RESET_VECTOR`.
- Reset asserted mid-operation takes effect immediately (asynchronous). Any pending redirect is lost.
- Redirect latency: target appears on `next_pc` in the same cycle as the request; `current_pc` equals the target one clock later. `flush` is high for exactly that later cycle.
- Back-to-back redirects on consecutive cycles give `flush` high for consecutive cycles, and the count increments each time.
- `mepc` updates on the clock edge of the trap cycle. An `mret_req` on the very next cycle uses the new value.

## Configuration
- `PC_SEQ_MISALIGN_CHECK_EN` defined:
  - A jump, branch or mret target with `[1:0] != 0` is not taken. It is converted to a trap: `next_pc = TRAP_VECTOR`, `mepc <=` the misaligned target.
  - Adds output `misalign_trap` (1 bit, reset 0), registered and high in the cycle after the conversion.
- Macro undefined: target bits `[1:0]` are forced to 0 and no trap is raised. The `misalign_trap` port does not exist.

## Structure
- `pc_seq_pkg` holds:
  - the state enum (BOOT/RUN/HALT);
  - the redirect-source encoding (NONE/TRAP/MRET/JUMP/BRANCH);
  - the `PC_STEP = 4` constant.
- One sub-module, `pc_redirect_arbiter`: purely combinational priority select that returns the source and target. The FSM, `mepc`, `flush` and the counter stay in `pc_sequencer`.

## Test plan
- Reset release -> one BOOT cycle with `next_pc = 0` and `fetch_req = 0`. Then with `fetch_ack = 1` every cycle, `current_pc` runs 0, 4, 8, 12.
- `current_pc = 0x20`, `stall = 1` for 3 cycles -> PC holds at 0x20 and `flush` stays 0. After release: 0x24.
- `branch_taken`, `jump_valid` (target 0x80) and `stall` in the same cycle -> PC = 0x80 next cycle, `flush` high one cycle, `redirect_cnt` = 1.
- Trap at `current_pc = 0x44` -> PC = 0x100 and `mepc` = 0x44. `mret_req` on the next cycle -> PC = 0x44. `redirect_cnt` +2.
- `halt_req` at 0x10 -> `fetch_req` = 0 and PC stays 0x10 while `branch_taken` pulses. `resume` -> 0x14 after `fetch_ack`.
- With `PC_SEQ_MISALIGN_CHECK_EN`: jump to 0x82 -> PC = 0x100, `mepc` = 0x82, `misalign_trap` pulses. Without the macro: PC = 0x80.
